// File: rtl/jtframe_dwnld_sdram.sv
// Turns the ioctl byte stream of a ROM download into 16-bit masked SDRAM
// write requests, buffered by a 4-entry FIFO. Define JTFRAME_DWNLD_PROM_EN to
// send bytes at or above PROM_START to a PROM write pulse instead of SDRAM.
module jtframe_dwnld_sdram #(
  parameter logic [24:0] BA1_START  = 25'h10_0000,
  parameter logic [24:0] BA2_START  = 25'h20_0000,
  parameter logic [24:0] BA3_START  = 25'h30_0000,
  parameter logic [24:0] PROM_START = 25'h1F0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_rom_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  typedef struct packed {
    logic [1:0]  ba;
    logic [22:0] offset;
    logic [7:0]  data;
    logic        a0;
    logic        prom;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 4;

  state_t      state_d, state_q;
  entry_t      mem_d [DEPTH];
  entry_t      mem_q [DEPTH];
  logic [1:0]  wr_ptr_d, wr_ptr_q;
  logic [1:0]  rd_ptr_d, rd_ptr_q;
  logic [2:0]  count_d, count_q;
  logic        overflow_d, overflow_q;
  logic [21:0] prog_addr_d, prog_addr_q;
  logic [15:0] prog_data_d, prog_data_q;
  logic [1:0]  prog_mask_d, prog_mask_q;
  logic [1:0]  prog_ba_d, prog_ba_q;
  logic        prog_we_d, prog_we_q;
`ifdef JTFRAME_DWNLD_PROM_EN
  logic        prom_we_d, prom_we_q;
`endif

  entry_t      new_entry;
  entry_t      head;
  logic [24:0] sel_start;
  logic [24:0] offset_full;
  logic        push_req, push, pop, full, empty;
  logic        unused_bits;

  assign full     = (count_q == 3'(DEPTH));
  assign empty    = (count_q == 3'd0);
  assign head     = mem_q[rd_ptr_q];
  assign push_req = downloading & ioctl_rom_wr;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  // Address decode: highest region start not above the byte address wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    new_entry = '0;
    sel_start = '0;
    if (ioctl_addr >= BA3_START) begin
      new_entry.ba = 2'd3;
      sel_start    = BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      new_entry.ba = 2'd2;
      sel_start    = BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      new_entry.ba = 2'd1;
      sel_start    = BA1_START;
    end
`ifdef JTFRAME_DWNLD_PROM_EN
    if (ioctl_addr >= PROM_START) begin
      new_entry.prom = 1'b1;
      sel_start      = PROM_START;
    end
`endif
    offset_full      = ioctl_addr - sel_start;
    new_entry.offset = offset_full[22:0];
    new_entry.data   = ioctl_data;
    new_entry.a0     = ioctl_addr[0];
  end

  // Sequencer: latches the head entry into the request registers and
  // retires it when the SDRAM controller acknowledges.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    prog_we_d   = prog_we_q;
    pop         = 1'b0;
`ifdef JTFRAME_DWNLD_PROM_EN
    prom_we_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
`ifdef JTFRAME_DWNLD_PROM_EN
          if (head.prom) begin
            pop         = 1'b1;
            prom_we_d   = 1'b1;
            prog_addr_d = head.offset[21:0];
            prog_data_d = {8'h00, head.data};
          end else begin
            state_d     = ST_WRITE;
            prog_we_d   = 1'b1;
            prog_addr_d = head.offset[22:1];
            prog_data_d = {head.data, head.data};
            prog_mask_d = head.a0 ? 2'b01 : 2'b10;
            prog_ba_d   = head.ba;
          end
`else
          state_d     = ST_WRITE;
          prog_we_d   = 1'b1;
          prog_addr_d = head.offset[22:1];
          prog_data_d = {head.data, head.data};
          prog_mask_d = head.a0 ? 2'b01 : 2'b10;
          prog_ba_d   = head.ba;
`endif
        end
      end
      ST_WRITE: begin
        if (prog_rdy) begin
          pop       = 1'b1;
          prog_we_d = 1'b0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // Guarantees prog_we is low for at least one cycle between requests.
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        prog_we_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prog_ba_q   <= '0;
      prog_we_q   <= 1'b0;
`ifdef JTFRAME_DWNLD_PROM_EN
      prom_we_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      prog_we_q   <= prog_we_d;
`ifdef JTFRAME_DWNLD_PROM_EN
      prom_we_q   <= prom_we_d;
`endif
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read once the reset count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_ba    = prog_ba_q;
  assign prog_we    = prog_we_q;
  assign overflow   = overflow_q;
  assign dwnld_busy = downloading | ~empty | (state_q != ST_IDLE);
`ifdef JTFRAME_DWNLD_PROM_EN
  assign prom_we    = prom_we_q;
`else
  assign prom_we    = 1'b0;
`endif

  assign unused_bits = ^{offset_full[24:23], head.offset[0], head.prom, PROM_START[0]};

endmodule

// File: tb/tb_jtframe_dwnld_sdram.sv
// Directed bench for jtframe_dwnld_sdram: bank decode, masks, latency,
// FIFO ordering/overflow, reset mid-write and (with the macro) PROM writes.
module tb_jtframe_dwnld_sdram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_rom_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        prom_we;
  logic        dwnld_busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  jtframe_dwnld_sdram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .downloading  (downloading),
    .ioctl_addr   (ioctl_addr),
    .ioctl_data   (ioctl_data),
    .ioctl_rom_wr (ioctl_rom_wr),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_mask    (prog_mask),
    .prog_ba      (prog_ba),
    .prog_we      (prog_we),
    .prog_rdy     (prog_rdy),
    .prom_we      (prom_we),
    .dwnld_busy   (dwnld_busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    downloading  = 1'b0;
    ioctl_rom_wr = 1'b0;
    prog_rdy     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr   = a;
    ioctl_data   = d;
    ioctl_rom_wr = 1'b1;
    tick();
    ioctl_rom_wr = 1'b0;
  endtask

  // Waits (bounded) for a request, captures it, acknowledges it with prog_rdy.
  task automatic serve_write(output logic ok, output logic [21:0] a, output logic [15:0] d,
                             output logic [1:0] m, output logic [1:0] b);
    ok = 1'b0; a = '0; d = '0; m = '0; b = '0;
    for (int i = 0; i < 20; i++) begin
      if (prog_we) begin
        ok = 1'b1; a = prog_addr; d = prog_data; m = prog_mask; b = prog_ba;
        break;
      end
      tick();
    end
    if (ok) begin
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
    end
  endtask

  task automatic count_we(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (prog_we) seen++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({prog_we, prom_we, overflow, dwnld_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {prog_we, prom_we, overflow, dwnld_busy});
    end
    total++;
    if ({prog_addr, prog_data, prog_mask, prog_ba} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h data=%h mask=%b ba=%0d want all 0",
               prog_addr, prog_data, prog_mask, prog_ba);
    end
  endtask

  task automatic test_basic();
    downloading = 1'b1;
    strobe(25'h000004, 8'hA5);
    total++;
    if ({prog_we, dwnld_busy} !== 2'b01) begin
      bad++;
      $display("FAIL basic_one_cycle got we,busy=%b want=01", {prog_we, dwnld_busy});
    end
    tick();
    total++;
    if ({prog_we, prog_addr, prog_data, prog_mask, prog_ba} !== {1'b1, 22'd2, 16'hA5A5, 2'b10, 2'd0}) begin
      bad++;
      $display("FAIL basic_request got we=%b addr=%h data=%h mask=%b ba=%0d want 1/2/a5a5/10/0",
               prog_we, prog_addr, prog_data, prog_mask, prog_ba);
    end
    tick();
    tick();
    total++;
    if ({prog_we, prog_addr, prog_data, prog_mask, prog_ba} !== {1'b1, 22'd2, 16'hA5A5, 2'b10, 2'd0}) begin
      bad++;
      $display("FAIL basic_hold got we=%b addr=%h data=%h mask=%b ba=%0d want 1/2/a5a5/10/0",
               prog_we, prog_addr, prog_data, prog_mask, prog_ba);
    end
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    total++;
    if (prog_we !== 1'b0) begin
      bad++;
      $display("FAIL basic_drop got prog_we=%b want=0", prog_we);
    end
    tick();
    downloading = 1'b0;
    tick();
    total++;
    if (dwnld_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_busy got=%b want=0", dwnld_busy);
    end
  endtask

  task automatic test_bank1();
    logic ok; logic [21:0] a; logic [15:0] d; logic [1:0] m, b;
    downloading = 1'b1;
    prog_rdy = 1'b1;  // a stray acknowledge while idle must be ignored
    tick();
    prog_rdy = 1'b0;
    strobe(25'h100003, 8'h5A);
    tick();
    tick();
    tick();
    total++;
    if (prog_we !== 1'b1) begin
      bad++;
      $display("FAIL bank1_waits_rdy got prog_we=%b want=1", prog_we);
    end
    serve_write(ok, a, d, m, b);
    total++;
    if ({ok, a, d, m, b} !== {1'b1, 22'd1, 16'h5A5A, 2'b01, 2'd1}) begin
      bad++;
      $display("FAIL bank1 got ok=%b addr=%h data=%h mask=%b ba=%0d want 1/1/5a5a/01/1", ok, a, d, m, b);
    end
    downloading = 1'b0;
  endtask

  task automatic test_boundaries();
    logic ok; logic [21:0] a; logic [15:0] d; logic [1:0] m, b;
    logic [24:0] addrs [5];
    logic [7:0]  datas [5];
    logic [41:0] exp   [5];
    addrs[0] = 25'h00F_FFFF; datas[0] = 8'h01; exp[0] = {22'h7FFFF, 16'h0101, 2'b01, 2'd0};
    addrs[1] = 25'h020_0000; datas[1] = 8'h02; exp[1] = {22'h00000, 16'h0202, 2'b10, 2'd2};
    addrs[2] = 25'h02F_FFFE; datas[2] = 8'h03; exp[2] = {22'h7FFFF, 16'h0303, 2'b10, 2'd2};
    addrs[3] = 25'h030_0000; datas[3] = 8'h04; exp[3] = {22'h00000, 16'h0404, 2'b10, 2'd3};
    addrs[4] = 25'h1F0_0011; datas[4] = 8'h3C; exp[4] = {22'h200008, 16'h3C3C, 2'b01, 2'd3};
    downloading = 1'b1;
`ifdef JTFRAME_DWNLD_PROM_EN
    for (int i = 0; i < 4; i++) begin
`else
    for (int i = 0; i < 5; i++) begin
`endif
      strobe(addrs[i], datas[i]);
      serve_write(ok, a, d, m, b);
      total++;
      if ({ok, a, d, m, b} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL boundary_%0d got ok=%b addr=%h data=%h mask=%b ba=%0d want addr=%h data=%h mask=%b ba=%0d",
                 i, ok, a, d, m, b, exp[i][41:20], exp[i][19:4], exp[i][3:2], exp[i][1:0]);
      end
    end
    downloading = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    int seen;
    downloading = 1'b0;
    strobe(25'h000010, 8'h99);
    total++;
    if (dwnld_busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_busy got=%b want=0", dwnld_busy);
    end
    count_we(8, seen);
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL ignored_write got %0d prog_we cycles want 0", seen);
    end
  endtask

  task automatic test_overflow();
    logic ok; logic [21:0] a; logic [15:0] d; logic [1:0] m, b;
    int seen;
    do_reset();
    downloading = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_addr   = 25'h10 + 25'(i);
      ioctl_data   = 8'h11 + 8'(i);
      ioctl_rom_wr = 1'b1;
      tick();
    end
    ioctl_rom_wr = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_flag got=%b want=1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      serve_write(ok, a, d, m, b);
      total++;
      if ({ok, a, d, m, b} !== {1'b1, 22'h8 + 22'(i / 2), {2{8'h11 + 8'(i)}},
                                 (i % 2 == 0) ? 2'b10 : 2'b01, 2'd0}) begin
        bad++;
        $display("FAIL overflow_order_%0d got ok=%b addr=%h data=%h mask=%b ba=%0d", i, ok, a, d, m, b);
      end
    end
    count_we(10, seen);
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL overflow_extra got %0d prog_we cycles want 0", seen);
    end
    downloading = 1'b0;
    tick();
    total++;
    if ({dwnld_busy, overflow} !== 2'b01) begin
      bad++;
      $display("FAIL overflow_sticky got busy,ovf=%b want=01", {dwnld_busy, overflow});
    end
  endtask

  task automatic test_push_pop();
    logic ok; logic [21:0] a; logic [15:0] d; logic [1:0] m, b;
    int seen;
    do_reset();
    downloading = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ioctl_addr   = 25'h40 + 25'(i);
      ioctl_data   = 8'h21 + 8'(i);
      ioctl_rom_wr = 1'b1;
      tick();
    end
    ioctl_rom_wr = 1'b0;
    total++;
    if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, 22'h20, 16'h2121, 2'b10}) begin
      bad++;
      $display("FAIL pushpop_head got we=%b addr=%h data=%h mask=%b want 1/20/2121/10",
               prog_we, prog_addr, prog_data, prog_mask);
    end
    prog_rdy     = 1'b1;
    ioctl_addr   = 25'h44;
    ioctl_data   = 8'h25;
    ioctl_rom_wr = 1'b1;
    tick();
    prog_rdy     = 1'b0;
    ioctl_rom_wr = 1'b0;
    total++;
    if ({overflow, prog_we} !== 2'b00) begin
      bad++;
      $display("FAIL pushpop_no_overflow got ovf,we=%b want=00", {overflow, prog_we});
    end
    for (int i = 1; i < 5; i++) begin
      serve_write(ok, a, d, m, b);
      total++;
      if ({ok, a, d, m, b} !== {1'b1, 22'h20 + 22'(i / 2), {2{8'h21 + 8'(i)}},
                                 (i % 2 == 0) ? 2'b10 : 2'b01, 2'd0}) begin
        bad++;
        $display("FAIL pushpop_order_%0d got ok=%b addr=%h data=%h mask=%b ba=%0d", i, ok, a, d, m, b);
      end
    end
    count_we(10, seen);
    total++;
    if ({seen != 0, overflow} !== 2'b00) begin
      bad++;
      $display("FAIL pushpop_tail got extra=%0d ovf=%b want 0/0", seen, overflow);
    end
    downloading = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int seen;
    do_reset();
    downloading = 1'b1;
    strobe(25'h000008, 8'h77);
    tick();
    total++;
    if (prog_we !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup got prog_we=%b want=1", prog_we);
    end
    rst_n       = 1'b0;
    downloading = 1'b0;
    tick();
    total++;
    if ({prog_we, prog_addr, prog_data, prog_mask} !== 41'd0) begin
      bad++;
      $display("FAIL midrst_clear got we=%b addr=%h data=%h mask=%b want all 0",
               prog_we, prog_addr, prog_data, prog_mask);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (dwnld_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_busy got=%b want=0", dwnld_busy);
    end
    count_we(8, seen);
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_abandon got %0d prog_we cycles want 0", seen);
    end
  endtask

`ifdef JTFRAME_DWNLD_PROM_EN
  task automatic test_prom();
    int pulses;
    int writes;
    do_reset();
    downloading = 1'b1;
    strobe(25'h1F0_0010, 8'h3C);
    tick();
    total++;
    if ({prom_we, prog_we, prog_addr, prog_data[7:0]} !== {1'b1, 1'b0, 22'd16, 8'h3C}) begin
      bad++;
      $display("FAIL prom_pulse got prom_we=%b prog_we=%b addr=%h data=%h want 1/0/10/3c",
               prom_we, prog_we, prog_addr, prog_data[7:0]);
    end
    pulses = 0;
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (prom_we) pulses++;
      if (prog_we) writes++;
    end
    total++;
    if ({pulses, writes} !== {32'd0, 32'd0}) begin
      bad++;
      $display("FAIL prom_single got extra prom_we=%0d prog_we=%0d want 0/0", pulses, writes);
    end
    downloading = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bank1();
    test_boundaries();
    test_ignored();
    test_overflow();
    test_push_pop();
    test_reset_mid_write();
`ifdef JTFRAME_DWNLD_PROM_EN
    test_prom();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_dwnld_sdram.md
JTFRAME_DWNLD_SDRAM -- requirements
Module: jtframe_dwnld_sdram

Interface
- REQ-001 SHALL have parameter BA1_START, default 25'h10_0000: first byte address mapped to SDRAM bank 1.
- REQ-002 SHALL have parameter BA2_START, default 25'h20_0000: first byte address mapped to bank 2.
- REQ-003 SHALL have parameter BA3_START, default 25'h30_0000: first byte address mapped to bank 3.
- REQ-004 SHALL have parameter PROM_START, default 25'h1F0_0000: first byte address of the PROM region.
- REQ-005 SHALL have port clk, in, 1: single clock; one clock, reset is synchronous and active-low.
- REQ-006 SHALL have port rst_n, in, 1: synchronous active-low reset.
- REQ-007 SHALL have port downloading, in, 1: ROM download in progress.
- REQ-008 SHALL have port ioctl_addr, in, 25: byte address.
- REQ-009 SHALL have port ioctl_data, in, 8: byte data.
- REQ-010 SHALL have port ioctl_rom_wr, in, 1: one-cycle byte strobe.
- REQ-011 SHALL have ports prog_addr (out, 22: word address), prog_data (out, 16), prog_mask (out, 2: 1 = byte not written) and prog_ba (out, 2).
- REQ-012 SHALL have port prog_we, out, 1: SDRAM write request.
- REQ-013 SHALL have port prog_rdy, in, 1: write done, one-cycle pulse.
- REQ-014 SHALL have port prom_we, out, 1: PROM write pulse (macro only).
- REQ-015 SHALL have ports dwnld_busy (out, 1) and overflow (out, 1).

Function
- REQ-016 SHALL push {ba, offset, byte, addr[0], prom} into a 4-entry FIFO on each ioctl_rom_wr while downloading=1; strobes with downloading=0 SHALL be ignored.
- REQ-017 SHALL select the bank as the highest BAn_START <= ioctl_addr (bank 0 below BA1_START); offset = ioctl_addr - selected start.
- REQ-018 SHALL drive prog_addr = offset[22:1], prog_data = {byte,byte} and prog_mask = 2'b10 when addr[0]=0, 2'b01 when addr[0]=1.
- REQ-019 SHALL use FSM IDLE -> WRITE (FIFO non-empty, SDRAM entry; prog_we=1 from the next cycle) -> GAP (prog_rdy=1; pop, prog_we=0) -> IDLE.
- REQ-020 SHALL hold prog_addr, prog_data, prog_mask and prog_ba stable while prog_we=1.
- REQ-021 SHALL keep prog_we low for at least one cycle between requests.
- REQ-022 SHALL ignore prog_rdy outside WRITE.
- REQ-023 SHALL preserve FIFO order; a push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
- REQ-024 SHALL drop a push while the FIFO is full (4 entries, no simultaneous pop) and set overflow sticky until reset.
- REQ-025 SHALL drive dwnld_busy = downloading | FIFO non-empty | (state != IDLE), combinational from registers.
- REQ-026 SHALL produce 2 cycles of latency from strobe to prog_we rise when the FIFO is empty and the FSM is IDLE.

Reset
- REQ-027 SHALL, while rst_n=0 at a clk edge, empty the FIFO, set the FSM to IDLE, and clear prog_we, prom_we, overflow, prog_addr, prog_data, prog_mask and prog_ba to 0; this applies mid-write, abandoning the request.

Configuration
- REQ-028 SHALL, with JTFRAME_DWNLD_PROM_EN defined, route addresses >= PROM_START to PROM: in IDLE, a head entry with prom=1 SHALL pop and pulse prom_we for one cycle with prog_addr = PROM byte offset [21:0] and prog_data[7:0] = byte, without prog_we.
- REQ-029 SHALL, without JTFRAME_DWNLD_PROM_EN, tie prom_we to 0 and treat PROM_START as bank 3 space.

Verification
- REQ-030 SHALL check: byte 8'hA5 at addr 25'h000004 -> prog_we 2 cycles later, prog_addr=2, prog_ba=0, prog_data=16'hA5A5, prog_mask=2'b10; drops the cycle after prog_rdy.
- REQ-031 SHALL check: addr 25'h100003 -> prog_ba=1, prog_addr=1, prog_mask=2'b01.
- REQ-032 SHALL check: 6 back-to-back strobes with prog_rdy held low -> 4 stored, overflow=1, the first 4 written in order after prog_rdy is released.
- REQ-033 SHALL check: push and pop in the same cycle with FIFO count 4 -> no overflow, count stays 4.
- REQ-034 SHALL check: rst_n=0 during WRITE -> prog_we=0 next cycle, dwnld_busy=0 once downloading=0.
- REQ-035 SHALL check, with JTFRAME_DWNLD_PROM_EN: addr 25'h1F00010, byte 8'h3C -> one prom_we pulse, prog_addr=16, prog_data[7:0]=8'h3C, prog_we stays 0.
